// File: rtl/alu_sweep_ctrl.sv
// Self-test sequencer: latches one operand pair, sweeps the eight ALU opcodes and streams
// each settled sample out on a valid/ready beat while folding it into an 8-bit signature.
module alu_sweep_ctrl #(
    parameter int SETTLE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_opcode,
    input  logic [3:0] alu_f,
    input  logic       alu_carry_out,
    input  logic       alu_zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_idx,
    output logic [3:0] res_f,
    output logic       res_carry,
    output logic       res_zero,
    output logic [7:0] signature
);

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT} state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [2:0] op_q;
    logic       res_valid_q;
    logic [2:0] res_idx_q;
    logic [3:0] res_f_q;
    logic       res_carry_q;
    logic       res_zero_q;
    logic [7:0] sig_q;
    logic [7:0] sig_d;

    // Signature folds the beat currently being handed over, so it uses the held res_* values.
    always_comb begin
        sig_d = {sig_q[6:0], sig_q[7]} ^ {1'b0, res_carry_q, res_zero_q, 1'b0, res_f_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alu_a_q     <= 4'h0;
            alu_b_q     <= 4'h0;
            op_q        <= 3'h0;
            res_valid_q <= 1'b0;
            res_idx_q   <= 3'h0;
            res_f_q     <= 4'h0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            sig_q       <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        alu_a_q <= a_in;
                        alu_b_q <= b_in;
                        op_q    <= 3'h0;
                        cnt_q   <= RELOAD;
                        sig_q   <= 8'h00;
                        busy_q  <= 1'b1;
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q != 4'h0) begin
                        cnt_q <= cnt_q - 4'h1;
                    end else begin
                        res_f_q     <= alu_f;
                        res_carry_q <= alu_carry_out;
                        res_zero_q  <= alu_zero;
                        res_idx_q   <= op_q;
                        res_valid_q <= 1'b1;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        sig_q       <= sig_d;
                        op_q        <= op_q + 3'h1;
                        if (op_q == 3'h7) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            cnt_q   <= RELOAD;
                            state_q <= S_SETTLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = op_q;
    assign res_valid  = res_valid_q;
    assign res_idx    = res_idx_q;
    assign res_f      = res_f_q;
    assign res_carry  = res_carry_q;
    assign res_zero   = res_zero_q;
    assign signature  = sig_q;

endmodule

// File: doc/alu_sweep_ctrl.md
# alu_sweep_ctrl

Clocked self-test sequencer that drives the 4-bit ALU's operand and opcode inputs. It sweeps all eight opcodes over one latched operand pair, waits a programmable settle time per opcode, and samples `f`, `carry_out` and `zero`. Each sample goes out on a valid/ready result stream and is folded into an 8-bit signature. It sits between the ALU and a result consumer (UART formatter, scoreboard or debug register bank), and replaces the delay-driven stimulus sweep with synthesizable hardware.

## Interface

**Parameters**
- `SETTLE`, default 3: clock cycles between driving an opcode and sampling ALU outputs. Legal range is 1..15.

**Ports**
- `clk`, input, 1: the single clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: begins a sweep when sampled high in IDLE. Ignored otherwise.
- `a_in`, input, 4: operand A, latched on an accepted start.
- `b_in`, input, 4: operand B, latched on an accepted start.
- `busy`, output, 1: high from accepted start until the sweep completes.
- `done`, output, 1: one-cycle pulse when the sweep completes.
- `alu_a`, output, 4: drives ALU input `a`.
- `alu_b`, output, 4: drives ALU input `b`.
- `alu_opcode`, output, 3: drives ALU `opcode`.
- `alu_f`, input, 4: from ALU `f`.
- `alu_carry_out`, input, 1: from ALU `carry_out`.
- `alu_zero`, input, 1: from ALU `zero`.
- `res_valid`, output, 1: result beat valid.
- `res_ready`, input, 1: consumer ready.
- `res_idx`, output, 3: opcode the result belongs to.
- `res_f`, output, 4: captured result.
- `res_carry`, output, 1: captured carry.
- `res_zero`, output, 1: captured zero flag.
- `signature`, output, 8: running signature of accepted beats.

## Operation

- **FSM states:** IDLE, SETTLE, WAIT.
- **IDLE:** `busy`=0.
  - On `start`=1: latch `a_in`/`b_in` into `alu_a`/`alu_b`, set `alu_opcode`=0, load settle counter with SETTLE-1, clear `signature`, set `busy`=1, go to SETTLE.
- **SETTLE:**
  - If counter≠0: decrement.
  - If counter=0: capture `alu_f`, `alu_carry_out`, `alu_zero` into `res_*`, set `res_idx`=`alu_opcode`, set `res_valid`=1, go to WAIT.
- **WAIT:** `res_*` and `res_valid` stable until handshake (`res_valid` & `res_ready` at an edge). On handshake:
  - `res_valid`←0.
  - `signature` ← rotl(`signature`,1) XOR {1'b0, `res_carry`, `res_zero`, 1'b0, `res_f`}.
  - If `alu_opcode`=7: `busy`←0, `done`←1 for one cycle, go to IDLE. `alu_opcode` wraps to 0.
  - Otherwise: `alu_opcode`+1, reload counter with SETTLE-1, go to SETTLE.
- **Held values:**
  - `alu_a`/`alu_b` hold the latched operands for the whole sweep and after it.
  - `res_*` and `signature` hold after the sweep until the next accepted start.
- **`start` while busy:** ignored; no effect on operands, opcode or counter.
- **Reset (any time, including mid-sweep):** immediately forces all outputs to reset values and the FSM to IDLE. No partial beat survives.
- **Reset values:** `busy`, `done`, `res_valid`=0; `alu_a`, `alu_b`, `res_f`=4'h0; `alu_opcode`, `res_idx`=3'h0; `res_carry`, `res_zero`=0; `signature`=8'h00.

## Timing

- All outputs are registered. The ALU path is combinational, so a sample taken SETTLE cycles after an opcode change is stable.
- **First beat:** start accepted at edge E0 → `res_valid` high after edge E0+SETTLE.
- **Per opcode:** SETTLE cycles of settling plus at least 1 WAIT cycle.
- **Back-to-back sweep:** with `res_ready` tied high, a beat is accepted on the edge after it appears. The next beat appears SETTLE edges later.
- **Full sweep, `res_ready`=1:** the final handshake is at edge E0+8·(SETTLE+1). `done` is high for the following cycle, and `busy` falls on the same edge.
- **Consumer stall:** backpressure stretches WAIT indefinitely. `alu_opcode` does not advance while stalled.
- **`start` and final handshake on the same edge:** `start` is ignored (state is WAIT). It may be accepted from the next cycle.

## Test plan

The bench uses a stub ALU: `f` = `a` XOR {1'b0, `opcode`}, `carry_out` = `opcode`[0], `zero` = (`f`==0).

1. **Reset values:** assert `rst_n`=0 mid-sweep (opcode 3, WAIT) → all outputs at reset values within the same cycle. After release, state is IDLE and `busy`=0.
2. **Basic sweep:** SETTLE=3, `a_in`=4'b0101, `b_in`=4'b0011, `res_ready`=1, `start` pulse → 8 beats, `res_idx` 0..7, `res_f` = 5,4,7,6,1,0,3,2, `res_zero`=1 only at idx 5. `done` pulses at E0+32.
3. **Backpressure:** `res_ready`=0 for 10 cycles at idx 2 → `res_valid` and `res_*` are stable and `alu_opcode` stays 2. Sequence and values are identical to scenario 2 after release.
4. **Ignored start:** `start` held high for the whole sweep → exactly one sweep, and `a_in` changes mid-sweep do not alter `alu_a`. A new sweep begins the cycle after `done` only if `start` is still high then.
5. **Signature:** with the stub replaced by constant outputs (`f`=0, `carry`=0, `zero`=0), `signature`=8'h00. With scenario 2's values, `signature` matches the bench reference model and holds after `done`.
6. **SETTLE=1 corner:** `res_ready`=1 → a beat every 2 cycles and `done` at E0+16.
